// File: rtl/whack_a_mole_fsm_if.sv
// Game-control bus between the button/timer front end and whack_a_mole_fsm.
// master drives buttons and remaining time; slave returns game status and mole timing wave.
interface whack_a_mole_fsm_if #(
    parameter int TMW = 15
);
    logic           reset_button_pressed;
    logic           start_button_pressed;
    logic [TMW-1:0] timer_milliseconds;
    logic           game_in_progress;
    logic           mole_clk;

    modport master (
        output reset_button_pressed,
        output start_button_pressed,
        output timer_milliseconds,
        input  game_in_progress,
        input  mole_clk
    );

    modport slave (
        input  reset_button_pressed,
        input  start_button_pressed,
        input  timer_milliseconds,
        output game_in_progress,
        output mole_clk
    );
endinterface

// File: rtl/whack_a_mole_fsm.sv
// Whack-a-mole game control: IDLE/PLAYING/GAME_OVER sequencing plus the mole_clk wave; outputs registered, 1-cycle latency.
// No backpressure; WHACK_A_MOLE_RESTART_EN lets a start in GAME_OVER begin a new game directly.
module whack_a_mole_fsm #(
    parameter int MOLE_UP_MS   = 800,
    parameter int MOLE_DOWN_MS = 400,
    parameter int MAX_TIMER_MS = 30000,
    parameter int CLKS_PER_MS  = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    whack_a_mole_fsm_if.slave  bus
);
    localparam int TMW       = $clog2(MAX_TIMER_MS + 1);
    localparam int PERIOD_MS = MOLE_UP_MS + MOLE_DOWN_MS;
    localparam int PHW       = (PERIOD_MS > 1) ? $clog2(PERIOD_MS) : 1;
    localparam int PRW       = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

    localparam logic [PRW-1:0] PRESC_LAST = PRW'(CLKS_PER_MS - 1);
    localparam logic [PHW-1:0] PHASE_LAST = PHW'(PERIOD_MS - 1);
    localparam logic [PHW-1:0] PHASE_UP   = PHW'(MOLE_UP_MS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PRW-1:0] presc_q, presc_d;
    logic [PHW-1:0] phase_q, phase_d;
    logic           gip_q, gip_d;
    logic           mole_q, mole_d;
    logic           entering;

    logic timer_nz;
    logic start_ok;
    logic tick;

    assign timer_nz = (bus.timer_milliseconds != TMW'(0));
    assign start_ok = bus.start_button_pressed && timer_nz;
    assign tick     = (presc_q == PRESC_LAST);

    always_comb begin
        state_d  = state_q;
        entering = 1'b0;
        if (bus.reset_button_pressed) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_d  = PLAYING;
                        entering = 1'b1;
                    end
                end
                PLAYING: begin
                    if (!timer_nz) state_d = GAME_OVER;
                end
                GAME_OVER: begin
`ifdef WHACK_A_MOLE_RESTART_EN
                    if (start_ok) begin
                        state_d  = PLAYING;
                        entering = 1'b1;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Counters only run while staying in PLAYING; any entry starts from a clean phase 0.
    always_comb begin
        presc_d = '0;
        phase_d = '0;
        if (state_d == PLAYING && !entering) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
            else      phase_d = phase_q;
        end
        gip_d  = (state_d == PLAYING);
        mole_d = gip_d && (phase_d < PHASE_UP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            phase_q <= '0;
            gip_q   <= 1'b0;
            mole_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            gip_q   <= gip_d;
            mole_q  <= mole_d;
        end
    end

    assign bus.game_in_progress = gip_q;
    assign bus.mole_clk         = mole_q;
endmodule

// File: tb/tb_whack_a_mole_fsm.sv
// Directed bench for whack_a_mole_fsm with UP=2, DOWN=1, CLKS_PER_MS=5, MAX_TIMER_MS=20 (10 high / 5 low cycles).
module tb_whack_a_mole_fsm;
    localparam int TMW = 5;

    typedef struct {
        logic  gip;
        logic  mole;
        string tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    whack_a_mole_fsm_if #(.TMW(TMW)) bus ();

    whack_a_mole_fsm #(
        .MOLE_UP_MS   (2),
        .MOLE_DOWN_MS (1),
        .MAX_TIMER_MS (20),
        .CLKS_PER_MS  (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic g, input logic m, input string tag);
        exp_t e;
        e.gip  = g;
        e.mole = m;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed gip=%0b mole=%0b required an expected entry",
                   bus.game_in_progress, bus.mole_clk);
        end else begin
            e = sb.pop_front();
            assert (bus.game_in_progress === e.gip && bus.mole_clk === e.mole) else begin
                errors++;
                $error("FAIL %s: observed gip=%0b mole=%0b expected gip=%0b mole=%0b",
                       e.tag, bus.game_in_progress, bus.mole_clk, e.gip, e.mole);
            end
        end
    endtask

    // Drive one cycle of inputs, record the expectation, then sample just after the edge.
    task automatic step(input logic rb, input logic st, input int tm,
                        input logic eg, input logic em, input string tag);
        bus.reset_button_pressed = rb;
        bus.start_button_pressed = st;
        bus.timer_milliseconds   = TMW'(tm);
        push_exp(eg, em, tag);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    function automatic logic wave(input int k);
        return (k % 15) < 10;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.reset_button_pressed = 1'b0;
        bus.start_button_pressed = 1'b0;
        bus.timer_milliseconds   = TMW'(20);

        #2;
        push_exp(1'b0, 1'b0, "rst_hold");
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 20, 1'b0, 1'b0, "idle_nostart");

        step(1'b1, 1'b0, 20, 1'b0, 1'b0, "rst_btn");
        step(1'b0, 1'b1, 20, 1'b1, 1'b1, "start");
        for (int k = 1; k <= 104; k++) begin
            if (k < 100) step(1'b0, 1'b0, 20 - k / 5, 1'b1, wave(k), "game_wave");
            else         step(1'b0, 1'b0, 0, 1'b0, 1'b0, "game_over");
        end

`ifdef WHACK_A_MOLE_RESTART_EN
        step(1'b0, 1'b1, 20, 1'b1, 1'b1, "start_in_over");
        for (int k = 1; k <= 14; k++) step(1'b0, 1'b0, 20, 1'b1, wave(k), "restart_wave");
`else
        step(1'b0, 1'b1, 20, 1'b0, 1'b0, "start_in_over");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 20, 1'b0, 1'b0, "over_hold");
`endif

        step(1'b1, 1'b0, 30, 1'b0, 1'b0, "rst_to_idle");
        step(1'b0, 1'b1, 30, 1'b1, 1'b1, "start2");
        for (int k = 1; k <= 22; k++) step(1'b0, 1'b0, 30, 1'b1, wave(k), "wave2");
        step(1'b1, 1'b0, 30, 1'b0, 1'b0, "rst_mid");
        step(1'b0, 1'b1, 30, 1'b1, 1'b1, "restart");
        for (int k = 1; k <= 16; k++) step(1'b0, 1'b0, 30, 1'b1, wave(k), "wave3");

        step(1'b1, 1'b0, 0, 1'b0, 1'b0, "rst3");
        step(1'b0, 1'b1, 0, 1'b0, 1'b0, "start_t0");
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, "idle_t0");
        step(1'b1, 1'b1, 20, 1'b0, 1'b0, "rst_and_start");
        step(1'b0, 1'b1, 20, 1'b1, 1'b1, "start_after");
        for (int k = 1; k <= 12; k++) step(1'b0, 1'b0, 20, 1'b1, wave(k), "wave4");

        // Drop rst_n between edges; outputs must clear without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(1'b0, 1'b0, "async_rst");
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 20, 1'b0, 1'b0, "after_async");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/whack_a_mole_fsm.md
# whack_a_mole_fsm

Game-control state machine for the whack-a-mole game. It sequences idle, playing and game-over states from the start and reset buttons and an externally supplied countdown. While a game runs it generates the mole timing clock `mole_clk`, a millisecond-accurate square wave that the mole-position logic consumes. It sits between the debounced button inputs and timer block and the mole/score datapath.

## Interface
- `MOLE_UP_MS`, default 800: milliseconds `mole_clk` is high per period; must be ≥1.
- `MOLE_DOWN_MS`, default 400: milliseconds `mole_clk` is low per period; must be ≥1.
- `MAX_TIMER_MS`, default 30000: largest game duration. Timer width TMW = $clog2(MAX_TIMER_MS+1).
- `CLKS_PER_MS`, default 50000: clock cycles per millisecond (50 MHz clock); must be ≥1.
- Derived: PERIOD_MS = MOLE_UP_MS+MOLE_DOWN_MS; phase width PHW = max(1, $clog2(PERIOD_MS)).
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous active-low hardware reset.
- `reset_button_pressed` in 1: synchronous, active-high, one-cycle game-reset pulse.
- `start_button_pressed` in 1: synchronous, active-high, one-cycle start pulse.
- `timer_milliseconds` in TMW: remaining game time in ms, counted down externally; unsigned.
- `game_in_progress` out 1: registered; high only in PLAYING.
- `mole_clk` out 1: registered; mole timing wave, low outside PLAYING.

## Operation
- States: IDLE, PLAYING, GAME_OVER. `rst_n` low forces IDLE, clears all counters, and drives both outputs to 0.
- Transition priority, highest first:
  1. `reset_button_pressed` moves any state to IDLE and clears the counters.
  2. From IDLE: `start_button_pressed` with `timer_milliseconds` ≠ 0 moves to PLAYING. A start with the timer at 0 is ignored.
  3. From PLAYING: `timer_milliseconds` == 0 moves to GAME_OVER.
  4. From GAME_OVER: start is ignored; only a reset-button pulse returns to IDLE.
- Millisecond prescaler: counts 0..CLKS_PER_MS-1 in PLAYING only; the tick is asserted at the terminal count. Cleared on entry to PLAYING.
- Phase counter: counts 0..PERIOD_MS-1 and advances on each tick, wrapping to 0. Cleared on entry to PLAYING.
- `mole_clk` = PLAYING && phase < MOLE_UP_MS.
- Button inputs are assumed debounced, single-cycle and synchronous to `clk`. Held levels are tolerated: a held start re-fires only in IDLE.

## Timing
- Outputs are registered from the next-state and next-counter values.
- The start pulse sampled at edge N sets `game_in_progress`=1 and `mole_clk`=1 immediately after edge N.
- Steady state: `mole_clk` is high for MOLE_UP_MS×CLKS_PER_MS cycles, then low for MOLE_DOWN_MS×CLKS_PER_MS cycles, repeating with no drift.
- Timer at 0 sampled at edge M in PLAYING: both outputs are 0 after edge M.
- A reset-button pulse sampled at edge K: both outputs are 0 after edge K.
- Simultaneous reset and start: reset wins and the state stays IDLE. A start in the next cycle is accepted.
- Reset mid-game: the phase restarts at 0 on the next start, with no residual prescaler count.
- `rst_n` assertion takes effect immediately, without waiting for a clock edge. Deassertion must be synchronous to `clk` (handled externally).

## Configuration
- `WHACK_A_MOLE_RESTART_EN` defined: in GAME_OVER, `start_button_pressed` with `timer_milliseconds` ≠ 0 goes directly to PLAYING, with counters cleared as for a normal start.
- `WHACK_A_MOLE_RESTART_EN` undefined: GAME_OVER leaves only via the reset button or `rst_n`.

## Test plan
All scenarios use MOLE_UP_MS=2, MOLE_DOWN_MS=1, CLKS_PER_MS=5, MAX_TIMER_MS=20.

- `rst_n` low, then release; hold `timer_milliseconds`=20 and give no start -> both outputs stay 0 indefinitely.
- Reset pulse then start pulse with timer 20 -> `game_in_progress`=1 next cycle; `mole_clk` repeats 10 cycles high, 5 cycles low.
- Decrement the timer 1 per 5 cycles to 0 -> both outputs go to 0 one edge after 0 is sampled. A later start is ignored (macro off) or restarts the game (macro on).
- Load timer 30, reset pulse, start pulse mid-phase of the previous game -> `mole_clk` restarts a full 10-cycle high phase.
- Start with the timer at 0 -> remains IDLE. Reset and start in the same cycle -> remains IDLE.
- Assert `rst_n` low mid-game, asynchronously between edges -> outputs drop to 0 immediately.
